// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line, centre-sampled on a
// bclk running at OSR times the baud rate (the same bclk that drives uart_tx).
//
// Ports:
//   bclk     - oversampling clock (OSR x baud)
//   reset    - asynchronous, active-high reset
//   rxd      - serial input, asynchronous to bclk, idle high
//   rx_dout  - last correctly received byte; bits at and above Lframe read 0
//   rx_ready - one-cycle strobe, rx_dout updated in the same cycle
//   rx_ferr  - one-cycle strobe, stop bit sampled low
//   rx_busy  - high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned Lframe = 8,  // data bits per frame, 1..8
    parameter int unsigned OSR    = 16  // bclk cycles per bit, even and >= 4
) (
    input  logic       bclk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_dout,
    output logic       rx_ready,
    output logic       rx_ferr,
    output logic       rx_busy
);

    localparam int unsigned CntW = $clog2(OSR);
    localparam logic [CntW-1:0] CntHalf = CntW'(OSR / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OSR - 1);
    localparam logic [3:0] BitLast = 4'(Lframe - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      dout_q, dout_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic [1:0]      sync_q;
    logic            rxd_s;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a falling edge.
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s = sync_q[1];

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        ready_d  = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                if (!rxd_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Re-check at the start-bit centre; a line already back high
                // was only a glitch.
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d                   = '0;
                    // Only indices below Lframe are ever written, so the
                    // upper bits of the shift register stay at their reset 0.
                    shift_d[bitcnt_q[2:0]] = rxd_s;
                    if (bitcnt_q == BitLast) begin
                        bitcnt_d = '0;
                        state_d  = StStop;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        dout_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // Hold off until the line is released so a long break is
                // not mistaken for a new start bit.
                if (rxd_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_dout  = dout_q;
    assign rx_ready = ready_q;
    assign rx_ferr  = ferr_q;
    assign rx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-plus-random bench for uart_rx. A behavioural transmitter
// drives the line; expected bytes and strobe times come from frame-level
// arithmetic (bit period, centre point, synchronizer delay).
module tb_uart_rx;

    localparam int Lframe = 8;
    localparam int OSR    = 16;
    localparam int SyncLat = 2;
    // Cycle offset, from the negedge where rxd falls, at which the bench's
    // post-edge sampler first sees a strobe: stop-bit centre + sync delay,
    // plus one because that negedge precedes bclk edge 0.
    localparam int StrobeOff = 1 + OSR * (Lframe + 1) + OSR / 2 + SyncLat;
    localparam int BusyRise  = 1 + SyncLat;

    logic       bclk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_dout;
    logic       rx_ready;
    logic       rx_ferr;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic busy_prev = 1'b0;

    int rdy_t[$];
    int rdy_d[$];
    int ferr_t[$];
    int brise[$];
    int bfall[$];

    uart_rx #(
        .Lframe(Lframe),
        .OSR   (OSR)
    ) dut (
        .bclk    (bclk),
        .reset   (reset),
        .rxd     (rxd),
        .rx_dout (rx_dout),
        .rx_ready(rx_ready),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy)
    );

    always #5 bclk = ~bclk;

    // Sample every output 1 time unit after each rising edge.
    always begin
        @(posedge bclk);
        #1;
        cyc++;
        if (rx_ready === 1'b1) begin
            rdy_t.push_back(cyc);
            rdy_d.push_back(int'(rx_dout));
        end
        if (rx_ferr === 1'b1) ferr_t.push_back(cyc);
        if (rx_busy === 1'b1 && !busy_prev) brise.push_back(cyc);
        if (rx_busy !== 1'b1 && busy_prev) bfall.push_back(cyc - 1);
        busy_prev = (rx_busy === 1'b1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_q();
        rdy_t.delete();
        rdy_d.delete();
        ferr_t.delete();
        brise.delete();
        bfall.delete();
    endtask

    // Behavioural transmitter (uart_tx stand-in); must be entered on a negedge
    // and returns on the negedge that ends the stop bit, leaving rxd at the
    // stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        rxd = 1'b0;
        t0  = cyc;
        repeat (OSR) @(negedge bclk);
        for (int i = 0; i < Lframe; i++) begin
            rxd = b[i];
            repeat (OSR) @(negedge bclk);
        end
        rxd = stop_bit;
        repeat (OSR) @(negedge bclk);
    endtask

    initial begin
        int t0;
        int t1;
        int exp_dout;
        logic [7:0] lb[$];
        logic [7:0] cb;

        // Reset state
        #3;
        chk("reset_dout", int'(rx_dout), 0);
        chk("reset_ready", int'(rx_ready), 0);
        chk("reset_ferr", int'(rx_ferr), 0);
        chk("reset_busy", int'(rx_busy), 0);
        repeat (3) @(negedge bclk);
        reset = 1'b0;
        repeat (5) @(negedge bclk);
        exp_dout = 0;

        // Single frame 0xA5
        clear_q();
        send_frame(8'hA5, 1'b1, t0);
        exp_dout = 'hA5;
        chk("a5_ready_count", rdy_t.size(), 1);
        chk("a5_ready_time", rdy_t[0], t0 + StrobeOff);
        chk("a5_dout", rdy_d[0], exp_dout);
        chk("a5_ferr_count", ferr_t.size(), 0);
        chk("a5_busy_rise", brise[0], t0 + BusyRise);
        chk("a5_busy_fall", bfall[0], t0 + StrobeOff - 1);
        chk("a5_ready_low_after", int'(rx_ready), 0);

        // Back-to-back 0x00 then 0xFF
        clear_q();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        exp_dout = 'hFF;
        chk("b2b_ready_count", rdy_t.size(), 2);
        chk("b2b_first_time", rdy_t[0], t0 + StrobeOff);
        chk("b2b_spacing", rdy_t[1] - rdy_t[0], OSR * (Lframe + 2));
        chk("b2b_first_dout", rdy_d[0], 'h00);
        chk("b2b_second_dout", rdy_d[1], 'hFF);
        chk("b2b_ferr_count", ferr_t.size(), 0);

        // Glitch: 4 cycles low
        clear_q();
        rxd = 1'b0;
        t0  = cyc;
        repeat (4) @(negedge bclk);
        rxd = 1'b1;
        repeat (30) @(negedge bclk);
        chk("glitch_ready_count", rdy_t.size(), 0);
        chk("glitch_ferr_count", ferr_t.size(), 0);
        chk("glitch_busy_rise", brise[0], t0 + BusyRise);
        chk("glitch_busy_fall", bfall[0], t0 + 1 + OSR / 2 + SyncLat - 1);
        chk("glitch_busy_len", bfall[0] - brise[0] + 1, OSR / 2);
        chk("glitch_dout_kept", int'(rx_dout), exp_dout);

        // Framing error: 0x3C with low stop, line low 40 cycles from stop start
        clear_q();
        send_frame(8'h3C, 1'b0, t0);
        repeat (40 - OSR) @(negedge bclk);
        rxd = 1'b1;
        repeat (20) @(negedge bclk);
        chk("ferr_count", ferr_t.size(), 1);
        chk("ferr_time", ferr_t[0], t0 + StrobeOff);
        chk("ferr_no_ready", rdy_t.size(), 0);
        chk("ferr_dout_kept", int'(rx_dout), exp_dout);
        chk("ferr_single_busy", brise.size(), 1);
        // Released at the negedge after edge 183, seen two cycles later.
        chk("ferr_break_exit", bfall[0], t0 + 1 + OSR * (Lframe + 2) + 40 - OSR + SyncLat - 1);
        clear_q();
        send_frame(8'h5A, 1'b1, t0);
        exp_dout = 'h5A;
        chk("after_ferr_count", rdy_t.size(), 1);
        chk("after_ferr_dout", rdy_d[0], exp_dout);
        chk("after_ferr_time", rdy_t[0], t0 + StrobeOff);

        // Reset at edge 80 of a frame
        clear_q();
        cb  = 8'hC3;
        rxd = 1'b0;
        repeat (OSR) @(negedge bclk);
        for (int i = 0; i < 4; i++) begin
            rxd = cb[i];
            repeat (OSR) @(negedge bclk);
        end
        @(posedge bclk);
        #2;
        reset = 1'b1;
        #1;
        exp_dout = 0;
        chk("rst_dout", int'(rx_dout), exp_dout);
        chk("rst_ready", int'(rx_ready), 0);
        chk("rst_ferr", int'(rx_ferr), 0);
        chk("rst_busy", int'(rx_busy), 0);
        rxd = 1'b1;
        repeat (3) @(negedge bclk);
        reset = 1'b0;
        repeat (OSR * (Lframe + 2)) @(negedge bclk);
        chk("rst_no_ready", rdy_t.size(), 0);
        chk("rst_no_ferr", ferr_t.size(), 0);
        clear_q();
        send_frame(8'h81, 1'b1, t0);
        exp_dout = 'h81;
        chk("post_rst_count", rdy_t.size(), 1);
        chk("post_rst_dout", rdy_d[0], exp_dout);

        // Loopback sequence plus random bytes and random idle gaps
        lb = '{8'h00, 8'h55, 8'hAA, 8'hFF};
        for (int i = 0; i < 6; i++) lb.push_back(8'($urandom_range(0, 255)));
        foreach (lb[i]) begin
            clear_q();
            repeat ($urandom_range(0, 20)) @(negedge bclk);
            send_frame(lb[i], 1'b1, t0);
            exp_dout = int'(lb[i]);
            chk($sformatf("loop%0d_count", i), rdy_t.size(), 1);
            chk($sformatf("loop%0d_dout", i), rdy_d[0], exp_dout);
            chk($sformatf("loop%0d_time", i), rdy_t[0], t0 + StrobeOff);
            chk($sformatf("loop%0d_ferr", i), ferr_t.size(), 0);
        end
        repeat (10) @(negedge bclk);
        chk("final_busy", int'(rx_busy), 0);
        chk("final_dout", int'(rx_dout), exp_dout);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's uart_tx block.
- bclk runs at 16x the baud rate, the same bclk that drives uart_tx.
- Accepts an asynchronous serial line: 8N1 framing, LSB first, idle high.
- Recovers each byte by centre-sampling on the oversampled clock and presents it with a one-cycle valid strobe.
- Reports framing errors and busy status to the host logic.

Parameters:
- Lframe, 8, number of data bits per frame (1..8).
- OSR, 16, bclk cycles per bit; must be even and >= 4.

Ports:
- bclk  input  1  clock, 16x baud.
- reset  input  1  asynchronous, active-high reset.
- rxd  input  1  serial line, asynchronous to bclk, idle high.
- rx_dout  output  8  last correctly received byte. Bits above Lframe read 0.
- rx_ready  output  1  one-bclk pulse; rx_dout is updated in that same cycle.
- rx_ferr  output  1  one-bclk pulse; stop bit sampled low.
- rx_busy  output  1  high whenever state is not s_idle.

Behaviour:
- Synchronizer:
  - rxd passes through 2 flops (reset value 1); the output is rxd_s.
  - All decisions use rxd_s only, which adds 2 bclk latency.
- Reset values: state=s_idle, cnt=0, bitcnt=0, shift register=0, rx_dout=0, rx_ready=0, rx_ferr=0, rx_busy=0.
- Reset mid-frame aborts the frame silently. No rx_ready or rx_ferr is produced, and rx_dout is cleared to 0.
- rx_ready and rx_ferr default to 0 every cycle; they are asserted only at the transitions named below.
- s_idle:
  - cnt=0, bitcnt=0.
  - rxd_s==0 -> s_start.
- s_start:
  - cnt increments each bclk.
  - At cnt==OSR/2-1 with rxd_s==0: cnt<=0 -> s_data. This is the start-bit centre.
  - At cnt==OSR/2-1 with rxd_s==1: glitch rejected, cnt<=0 -> s_idle. No pulse is produced.
- s_data:
  - cnt increments each bclk.
  - At cnt==OSR-1: shift[bitcnt]<=rxd_s, cnt<=0, bitcnt<=bitcnt+1.
  - When the bit just sampled is bit Lframe-1: bitcnt<=0 -> s_stop.
- s_stop:
  - cnt increments each bclk.
  - At cnt==OSR-1 with rxd_s==1: rx_dout<=shift, rx_ready<=1, cnt<=0 -> s_idle.
  - At cnt==OSR-1 with rxd_s==0: rx_ferr<=1, rx_dout unchanged, cnt<=0 -> s_break.
- s_break:
  - Waits for rxd_s==1, then -> s_idle.
  - This prevents a held-low line (break condition) from being re-detected as a new start bit.
- Latency, with the rxd falling edge as bclk edge 0:
  - Start check at edge 10.
  - Data bit k sampled at edge 10+16*(k+1).
  - Stop bit sampled at edge 10+16*(Lframe+1), i.e. 154 for the defaults.
  - rx_ready is high for the single cycle after edge 154.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted.
  - The stop sample is at stop-bit centre + 2.
  - s_idle is re-entered about 6 bclk before the next falling edge is visible.
- cnt is 4 bits for OSR=16. Its width is $clog2(OSR) and it never wraps past OSR-1.
- bitcnt width is 4 bits.
- No buffering: a new byte overwrites rx_dout. The consumer must capture it on rx_ready.

Test Plan:
- Single frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), 16 bclk/bit, stop high:
  - rx_ready pulses exactly 1 cycle after edge 154.
  - rx_dout=0xA5.
  - rx_ferr stays 0.
  - rx_busy is high from edge 2 to edge 154.
- Back-to-back frames 0x00 then 0xFF, each with a single stop bit:
  - Two rx_ready pulses 160 bclk apart.
  - rx_dout reads 0x00, then 0xFF.
- Glitch: rxd low for 4 bclk, then high:
  - No rx_ready and no rx_ferr.
  - rx_busy is high for about 8 cycles.
  - The FSM returns to s_idle by edge 11.
- Framing error: 0x3C sent with the stop bit low, line held low 40 bclk, then high:
  - rx_ferr pulses 1 cycle at edge 154.
  - rx_dout keeps its previous value.
  - No new frame is detected until the line returns high; the next valid 0x5A is then received correctly.
- Reset asserted at edge 80 of a frame:
  - All outputs go to 0 immediately.
  - No pulse from the aborted frame.
  - A following frame 0x81 is received correctly.
- Loopback from uart_tx: uart_tx sends 0x00, 0x55, 0xAA, 0xFF on the shared bclk.
  - Every byte is matched on rx_dout.
  - rx_ferr is never asserted.
